// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory request/response bus for fetch_ctrl
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage sequencer: imem requests, stalls, redirects, timeout
module fetch_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic         trap,
  input  logic         mret,
  input  logic [31:0]  pc,
  fetch_ctrl_if.master imem,
  output logic [31:0]  inst,
  output logic         pc_en,
  output logic         PC_src,
  output logic         IF_ID_en,
  output logic         IF_flush,
  output logic         fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  // TIMEOUT=0 still needs a one-bit counter so the declarations stay legal
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          drop_q, drop_d;
  logic [31:0]   buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        tm_redir;
  logic        br_redir;
  logic        redir;
  logic [CW:0] cnt_inc;
  logic        tmo_hit;
  logic        deliver;
  logic        fault;

  // redirect qualification and timeout comparison shared by next-state and outputs
  always_comb begin
    tm_redir = trap | mret;
    // a faulted fetch unit only restarts through trap/mret
    br_redir = branch_taken && (state_q != S_FAULT) && !tm_redir;
    redir    = tm_redir | br_redir;
    cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    tmo_hit  = (TIMEOUT != 0) && (cnt_inc >= (CW + 1)'(TIMEOUT));
    deliver  = !stall && !redir &&
               (((state_q == S_WAIT) && !drop_q && imem.imem_rvalid) ||
                (state_q == S_HOLD));
  end

  // next-state: transaction tracking, stale-response discard, hold buffer, timeout
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fault   = 1'b0;
    case (state_q)
      S_REQ: begin
        // a redirect before acceptance simply moves the request to the new PC;
        // one accepted in the same cycle has to be tagged stale
        if (imem.imem_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          drop_d  = redir;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (redir || drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else if (stall) begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          if (redir) begin
            drop_d = 1'b1;
          end
          // saturate so a redirect on the deadline cycle re-fires the fault next cycle
          cnt_d = tmo_hit ? TMAX : cnt_inc[CW-1:0];
          if (tmo_hit && !tm_redir) begin
            fault   = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_HOLD: begin
        if (redir) begin
          buf_d   = NOP;
          state_d = S_REQ;
        end else if (!stall) begin
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        if (tm_redir) begin
          state_d = S_REQ;
          cnt_d   = '0;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // pipeline control outputs, redirect priority trap/mret > branch > stall > delivery
  always_comb begin
    inst     = NOP;
    pc_en    = 1'b0;
    PC_src   = 1'b0;
    IF_ID_en = 1'b1;
    IF_flush = 1'b1;
    if (tm_redir) begin
      // the fetch stage loads the trap/mret target itself
      IF_ID_en = 1'b0;
      IF_flush = 1'b0;
    end else if (br_redir) begin
      pc_en  = 1'b1;
      PC_src = 1'b1;
    end else if (stall) begin
      IF_ID_en = 1'b0;
      IF_flush = 1'b0;
    end else if (deliver) begin
      inst     = (state_q == S_HOLD) ? buf_q : imem.imem_rdata;
      pc_en    = 1'b1;
      IF_flush = 1'b0;
    end
    // otherwise a bubble: flush IF/ID so a held instruction is never replayed
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc;
  assign fetch_fault    = fault;

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      buf_q   <= NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  // flag order: {imem_req, pc_en, PC_src, IF_ID_en, IF_flush, fetch_fault}
  localparam logic [5:0] BUB_R = 6'b100110;
  localparam logic [5:0] BUB   = 6'b000110;
  localparam logic [5:0] DEL   = 6'b010100;
  localparam logic [5:0] STL   = 6'b000000;
  localparam logic [5:0] STL_R = 6'b100000;
  localparam logic [5:0] BR    = 6'b011110;
  localparam logic [5:0] BR_R  = 6'b111110;
  localparam logic [5:0] TRP   = 6'b000000;
  localparam logic [5:0] TRP_R = 6'b100000;
  localparam logic [5:0] FLT   = 6'b000111;

  typedef struct {
    logic        stall;
    logic        br;
    logic        trap;
    logic        mret;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [5:0]  flags;
    logic [31:0] inst;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall, branch_taken, trap, mret;
  logic [31:0] pc;
  logic        ready, rvalid;
  logic [31:0] rdata;

  logic [31:0] inst0, inst1;
  logic        pc_en0, pc_src0, ifid0, flush0, fault0;
  logic        pc_en1, pc_src1, ifid1, flush1, fault1;

  int total;
  int passed;

  fetch_ctrl_if bus0();
  fetch_ctrl_if bus1();

  assign bus0.imem_ready  = ready;
  assign bus0.imem_rvalid = rvalid;
  assign bus0.imem_rdata  = rdata;
  assign bus1.imem_ready  = ready;
  assign bus1.imem_rvalid = rvalid;
  assign bus1.imem_rdata  = rdata;

  fetch_ctrl #(.TIMEOUT(255)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .trap(trap), .mret(mret), .pc(pc), .imem(bus0.master),
    .inst(inst0), .pc_en(pc_en0), .PC_src(pc_src0), .IF_ID_en(ifid0),
    .IF_flush(flush0), .fetch_fault(fault0)
  );

  fetch_ctrl #(.TIMEOUT(4)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .trap(trap), .mret(mret), .pc(pc), .imem(bus1.master),
    .inst(inst1), .pc_en(pc_en1), .PC_src(pc_src1), .IF_ID_en(ifid1),
    .IF_flush(flush1), .fetch_fault(fault1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic b, logic t, logic m, logic rd, logic rv,
                              logic [31:0] d, logic [5:0] f, logic [31:0] i);
    vec_t v;
    v.stall = s; v.br = b; v.trap = t; v.mret = m;
    v.ready = rd; v.rvalid = rv; v.rdata = d; v.flags = f; v.inst = i;
    return v;
  endfunction

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got flags=%b inst=%h, want flags=%b inst=%h",
                  name, act[37:32], act[31:0], exp[37:32], exp[31:0]);
  endtask

  task automatic drive(input logic s, input logic b, input logic t, input logic m,
                       input logic rd, input logic rv, input logic [31:0] d);
    stall = s; branch_taken = b; trap = t; mret = m;
    ready = rd; rvalid = rv; rdata = d;
  endtask

  function automatic logic [37:0] out0();
    return {bus0.imem_req, pc_en0, pc_src0, ifid0, flush0, fault0, inst0};
  endfunction

  function automatic logic [37:0] out1();
    return {bus1.imem_req, pc_en1, pc_src1, ifid1, flush1, fault1, inst1};
  endfunction

  vec_t tbl[$];

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    pc     = 32'h0000_1000;
    drive(0, 0, 0, 0, 0, 0, 32'h0);

    // single-cycle delivery
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'h00500093, DEL,   32'h00500093));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        BUB_R, NOP));
    // response during a three-cycle stall
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(1,0,0,0,0,1,32'h00A00113, STL,   NOP));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,        STL,   NOP));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,        STL,   NOP));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        DEL,   32'h00A00113));
    // branch while waiting, stale word two cycles later
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(0,1,0,0,0,0,32'h0,        BR,    NOP));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        BUB,   NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'hDEADBEEF, BUB,   NOP));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        BUB_R, NOP));
    // trap coincident with a valid response
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(0,0,1,0,0,1,32'h11111111, TRP,   NOP));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        BUB_R, NOP));
    // mret before acceptance, spurious responses in REQ
    tbl.push_back(mk(0,0,0,1,0,0,32'h0,        TRP_R, NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'h22222222, BUB_R, NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'h22222222, BUB_R, NOP));
    // branch discards the hold buffer
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(1,0,0,0,0,1,32'h33333333, STL,   NOP));
    tbl.push_back(mk(1,1,0,0,0,0,32'h0,        BR,    NOP));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,        STL_R, NOP));
    // branch in the acceptance cycle tags the response stale
    tbl.push_back(mk(0,1,0,0,1,0,32'h0,        BR_R,  NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'h44444444, BUB,   NOP));
    tbl.push_back(mk(0,0,0,0,1,0,32'h0,        BUB_R, NOP));
    tbl.push_back(mk(0,0,0,0,0,1,32'h55555555, DEL,   32'h55555555));

    #3;
    check("reset_outputs", out0(), {BUB_R, NOP});
    total++;
    if (bus0.imem_addr === pc) passed++;
    else $display("FAIL reset_addr: got %h, want %h", bus0.imem_addr, pc);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].trap, tbl[i].mret,
            tbl[i].ready, tbl[i].rvalid, tbl[i].rdata);
      if (i == 12) pc = 32'h0000_2000;
      #3;
      check($sformatf("vec%0d", i), out0(), {tbl[i].flags, tbl[i].inst});
      if (i == 12) begin
        total++;
        if (bus0.imem_addr === 32'h0000_2000) passed++;
        else $display("FAIL redirect_addr: got %h, want 00002000", bus0.imem_addr);
      end
      @(posedge clk); #1;
    end

    // asynchronous reset abandons an accepted transaction
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("wait_before_reset", out0(), {BUB, NOP});
    rst = 1'b1;
    #1;
    check("async_reset", out0(), {BUB_R, NOP});
    @(posedge clk); #1;
    rst = 1'b0;

    // timeout on the TIMEOUT=4 instance
    drive(0, 0, 0, 0, 1, 0, 32'h0);
    #3;
    check("tmo_accept", out1(), {BUB_R, NOP});
    @(posedge clk); #1;
    for (int c = 1; c <= 4; c++) begin
      drive(0, 0, 0, 0, 0, 0, 32'h0);
      #3;
      check($sformatf("tmo_wait%0d", c), out1(), {(c == 4) ? FLT : BUB, NOP});
      if (c == 4) check("no_tmo_default", out0(), {BUB, NOP});
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #3;
    check("fault_idle", out1(), {BUB, NOP});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1, 32'h66666666);
    #3;
    check("fault_rvalid", out1(), {BUB, NOP});
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 0, 32'h0);
    #3;
    check("fault_branch", out1(), {BUB, NOP});
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    #3;
    check("fault_stall", out1(), {STL, NOP});
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    #3;
    check("fault_trap", out1(), {TRP, NOP});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    #3;
    check("after_trap", out1(), {BUB_R, NOP});
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
